// File: rtl/rvx_ram_arbiter.sv
// Round-robin arbiter sharing one RAM request/response port between an
// instruction-fetch manager (M0) and a data manager (M1), with a response watchdog.
module rvx_ram_arbiter #(
  parameter int unsigned RESPONSE_TIMEOUT = 15
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] m0_rw_address,
  input  logic        m0_read_request,
  input  logic        m0_write_request,
  input  logic [31:0] m0_write_data,
  input  logic [3:0]  m0_write_strobe,
  output logic [31:0] m0_read_data,
  output logic        m0_read_response,
  output logic        m0_write_response,
  input  logic [31:0] m1_rw_address,
  input  logic        m1_read_request,
  input  logic        m1_write_request,
  input  logic [31:0] m1_write_data,
  input  logic [3:0]  m1_write_strobe,
  output logic [31:0] m1_read_data,
  output logic        m1_read_response,
  output logic        m1_write_response,
  output logic [31:0] s_rw_address,
  output logic [31:0] s_write_data,
  output logic [3:0]  s_write_strobe,
  output logic        s_read_request,
  output logic        s_write_request,
  input  logic [31:0] s_read_data,
  input  logic        s_read_response,
  input  logic        s_write_response
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  localparam bit         WD_EN    = (RESPONSE_TIMEOUT != 32'd0);
  localparam logic [7:0] WD_LIMIT = 8'(RESPONSE_TIMEOUT);

  state_t      state_q, state_d;
  logic        last_grant_q, last_grant_d;
  logic        grant_q, grant_d;
  logic        rd_pend_q, rd_pend_d;
  logic        wr_pend_q, wr_pend_d;
  logic [7:0]  wd_q, wd_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  strb_q, strb_d;
  logic        rreq_q, rreq_d;
  logic        wreq_q, wreq_d;

  logic        m0_pend_s, m1_pend_s, sel_s, expire_s;
  logic        rd_done_s, wr_done_s, rd_left_s, wr_left_s;
  logic [31:0] rdata_s;

  assign m0_pend_s = m0_read_request | m0_write_request;
  assign m1_pend_s = m1_read_request | m1_write_request;

  // Next-state, arbitration and completion logic
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    rd_pend_d    = rd_pend_q;
    wr_pend_d    = wr_pend_q;
    wd_d         = wd_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    strb_d       = strb_q;
    rreq_d       = rreq_q;
    wreq_d       = wreq_q;
    sel_s        = 1'b0;
    expire_s     = 1'b0;
    rd_done_s    = 1'b0;
    wr_done_s    = 1'b0;
    rd_left_s    = 1'b0;
    wr_left_s    = 1'b0;
    rdata_s      = 32'd0;
    case (state_q)
      ST_IDLE: begin
        if (m0_pend_s || m1_pend_s) begin
          // Contention goes to whoever lost the previous grant
          sel_s        = (m0_pend_s && m1_pend_s) ? ~last_grant_q : m1_pend_s;
          grant_d      = sel_s;
          last_grant_d = sel_s;
          addr_d       = sel_s ? m1_rw_address    : m0_rw_address;
          wdata_d      = sel_s ? m1_write_data    : m0_write_data;
          strb_d       = sel_s ? m1_write_strobe  : m0_write_strobe;
          rreq_d       = sel_s ? m1_read_request  : m0_read_request;
          wreq_d       = sel_s ? m1_write_request : m0_write_request;
          rd_pend_d    = rreq_d;
          wr_pend_d    = wreq_d;
          state_d      = ST_ISSUE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        rreq_d  = 1'b0;
        wreq_d  = 1'b0;
        wd_d    = 8'd1;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        expire_s  = WD_EN && (wd_q == WD_LIMIT);
        rd_left_s = rd_pend_q & ~s_read_response;
        wr_left_s = wr_pend_q & ~s_write_response;
        // A forced completion pulses only what is still outstanding, with zero data
        rd_done_s = rd_pend_q & (s_read_response | expire_s);
        wr_done_s = wr_pend_q & (s_write_response | expire_s);
        rdata_s   = (rd_pend_q && s_read_response) ? s_read_data : 32'd0;
        if (expire_s || !(rd_left_s || wr_left_s)) begin
          rd_pend_d = 1'b0;
          wr_pend_d = 1'b0;
          wd_d      = 8'd0;
          state_d   = ST_IDLE;
        end else begin
          rd_pend_d = rd_left_s;
          wr_pend_d = wr_left_s;
          wd_d      = (wd_q == 8'hFF) ? wd_q : wd_q + 8'd1;
          state_d   = ST_WAIT;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and request registers with synchronous active-low reset
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      last_grant_q <= 1'b1;
      grant_q      <= 1'b0;
      rd_pend_q    <= 1'b0;
      wr_pend_q    <= 1'b0;
      wd_q         <= 8'd0;
      addr_q       <= 32'd0;
      wdata_q      <= 32'd0;
      strb_q       <= 4'd0;
      rreq_q       <= 1'b0;
      wreq_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      rd_pend_q    <= rd_pend_d;
      wr_pend_q    <= wr_pend_d;
      wd_q         <= wd_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      strb_q       <= strb_d;
      rreq_q       <= rreq_d;
      wreq_q       <= wreq_d;
    end
  end

  assign s_rw_address    = addr_q;
  assign s_write_data    = wdata_q;
  assign s_write_strobe  = strb_q;
  assign s_read_request  = rreq_q;
  assign s_write_request = wreq_q;

  assign m0_read_response  = rd_done_s & ~grant_q;
  assign m0_write_response = wr_done_s & ~grant_q;
  assign m0_read_data      = grant_q ? 32'd0 : rdata_s;
  assign m1_read_response  = rd_done_s & grant_q;
  assign m1_write_response = wr_done_s & grant_q;
  assign m1_read_data      = grant_q ? rdata_s : 32'd0;

endmodule

// File: doc/rvx_ram_arbiter.md
# rvx_ram_arbiter

Two-manager arbiter that sits directly upstream of the on-chip RAM and shares its single request/response port between an instruction-fetch manager (M0) and a data manager (M1). It grants one transaction at a time with round-robin priority, registers the forwarded request, and routes the RAM's one-cycle-later response back to the granted manager. A response watchdog guarantees that a manager never hangs on a subordinate that fails to answer.

## Interface
Parameters:
- RESPONSE_TIMEOUT, 15: cycles to wait for a subordinate response before a forced response; 0 disables the watchdog; legal range 0..255.

Ports:
- clock  input  1  single clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-low (0 = reset), sampled on rising clock.
- mX_rw_address  input  32  byte address from manager X (X = 0, 1).
- mX_read_request  input  1  read request, held until the matching mX_read_response.
- mX_write_request  input  1  write request, held until the matching mX_write_response.
- mX_write_data  input  32  write data.
- mX_write_strobe  input  4  byte enables; bit n enables bits 8n+7:8n.
- mX_read_data  output  32  read data, valid only in the mX_read_response cycle; 0 otherwise.
- mX_read_response  output  1  one-cycle read completion pulse.
- mX_write_response  output  1  one-cycle write completion pulse.
- s_rw_address, s_write_data, s_write_strobe  output  32/32/4  registered copy of the granted manager's fields.
- s_read_request, s_write_request  output  1  registered one-cycle request pulses to the RAM.
- s_read_data  input  32  RAM read data.
- s_read_response, s_write_response  input  1  RAM completion pulses.

## Operation
- States: IDLE, ISSUE, WAIT.
- IDLE: a manager is pending if its read_request or write_request is high. If neither is pending, stay. If one is pending, grant it. If both are pending, grant the manager that did not win the last grant; the first arbitration after reset favours M0. On grant, capture address, data, strobe, and request bits into s_* registers, set last_grant, and go to ISSUE.
- ISSUE: s_read_request/s_write_request are high for exactly this cycle. Go to WAIT and clear the request bits; address, data, and strobe hold their values.
- WAIT: combinationally forward s_read_response, s_write_response, and s_read_data to the granted manager only; the other manager sees 0. Completion occurs when every issued request type has responded. Responses arrive in the same cycle for a combined read+write.
  - On completion, return to IDLE.
  - If the watchdog expires first, pulse the granted manager's outstanding response(s) with read_data = 0 and return to IDLE.
- Watchdog: counts WAIT cycles. It expires when the count reaches RESPONSE_TIMEOUT; the forced response is driven in that cycle.
- A manager asserting read and write together is served as one combined transaction. Both s_ requests are forwarded.
- Responses arriving in IDLE or ISSUE, or for a manager that is not granted, are ignored and never forwarded.
- The request of a non-granted manager stays pending and is never dropped.

## Timing
- Reset values: state IDLE, last_grant = M1 (so M0 wins first), all s_* outputs 0, all mX_*_response 0, mX_read_data 0, watchdog 0.
- Latency with the RAM, from the manager's request first seen in IDLE at cycle N:
  - s request pulse at N+1.
  - RAM response and manager response at N+2.
  - Back in IDLE at N+3.
- Throughput: one transaction per 3 cycles. A manager that drops its request at N+3 is not re-granted.
- Reset asserted mid-transaction: the next edge forces the reset values. No response is delivered for the aborted transaction, and any late RAM response is ignored.
- Address, data, and strobe are not checked; out-of-range handling belongs to the RAM.

## Test plan
- M0 read only at address 0x10, RAM word 0xDEADBEEF: s_read_request pulses 1 cycle later; m0_read_response with 0xDEADBEEF 2 cycles after the request; M1 outputs stay 0.
- M0 and M1 both write at cycle N (M0 0x11223344 strobe 0xF to 0x0; M1 0xAABBCCDD strobe 0x3 to 0x4): M0 is served first, M1 is granted at N+3. Readback gives 0x11223344 at 0x0 and low half 0xCCDD at 0x4.
- Both managers issue continuous reads: grants strictly alternate M0, M1, M0, M1, each 3 cycles apart.
- Subordinate never responds, RESPONSE_TIMEOUT = 4, M1 read: m1_read_response pulses 4 cycles after ISSUE with data 0; the FSM returns to IDLE and a following M0 read completes normally.
- Reset pulled low in the WAIT cycle: all outputs are 0 on the next edge, the late RAM response is ignored, and after reset release the first contended grant goes to M0.
- M1 combined read+write to 0x8: both s requests pulse together; m1 read and write responses pulse in the same cycle with the pre-write data.
